led_scanner: RTL and testbench
==============================

# led_scanner

Parametrised bouncing/wrapping LED scanner. A prescaler and speed divider generate a step strobe, and a position counter with a direction flag walks a single lit LED across an `N_LEDS`-wide bar. Supported patterns are bounce (Knight-Rider), wrap up, wrap down and hold. It drives the board LED bank directly and also exports position and step information to downstream display logic.

## Interface
- `N_LEDS`, default 8: number of LEDs; legal range 2..64.
- `PRESCALE`, default 1250000: clock cycles per base tick; legal minimum 1.
- `PW`, default `$clog2(N_LEDS)`: width of `POS`. Derived; do not override.
- `CLK` input, 1 bit: single clock; all state is on its rising edge.
- `RSTn` input, 1 bit: asynchronous, active-low reset.
- `ENABLE` input, 1 bit: run when high; freeze all state when low.
- `MODE` input, 2 bits: 00 bounce, 01 wrap up, 10 wrap down, 11 hold.
- `SPEED` input, 4 bits: step period is `PRESCALE*(SPEED+1)` cycles.
- `LEDS` output, `N_LEDS` bits: registered LED drive; bit `N_LEDS-1` is the leftmost LED.
- `POS` output, `PW` bits: registered index of the lit LED.
- `DIR` output, 1 bit: registered direction; 1 = increasing index, 0 = decreasing index.
- `STEP` output, 1 bit: one-cycle registered pulse marking a position update.

## Operation
- **Prescaler** `pcnt` runs 0..`PRESCALE-1` while `ENABLE`=1. A tick occurs when `pcnt`=`PRESCALE-1`, and `pcnt` then wraps to 0.
- **Divider** `dcnt` counts ticks from 0 up to `spd_q`.
  - A step occurs on a tick when `dcnt`=`spd_q`; `dcnt` then clears.
  - `spd_q` reloads from `SPEED` at reset-release and at every step. A `SPEED` change therefore affects the next period, never the current one.
- **ENABLE low:** `pcnt`, `dcnt`, `POS`, `DIR` and `LEDS` hold their values and `STEP` is 0. Counting resumes from the held counts.
- **On a step, by `MODE`:**
  - **Bounce:**
    - If `DIR`=0 and `POS`=0, then `DIR`←1 and `POS`←1.
    - If `DIR`=1 and `POS`=`N_LEDS-1`, then `DIR`←0 and `POS`←`N_LEDS-2`.
    - Otherwise `POS` moves by ±1 according to `DIR`.
    - Each end is visited exactly once per period. The period is `2*N_LEDS-2` steps.
  - **Wrap up:** `DIR`←1. `POS`←`POS+1`, with `N_LEDS-1` wrapping to 0.
  - **Wrap down:** `DIR`←0. `POS`←`POS-1`, with 0 wrapping to `N_LEDS-1`.
  - **Hold:** `POS` and `DIR` are unchanged. `STEP` still pulses.
- **MODE changes** are sampled only on step cycles; the new mode applies from the first step after the change. When switching from a wrap mode back to bounce, the bounce continues in the current `DIR`.
- **LEDS** equals one-hot(`POS`), plus the trail bit when the trail feature is compiled in (see Configuration). LEDs are never dark after reset.
- **Non-power-of-two N_LEDS:** `POS` never exceeds `N_LEDS-1`.

## Timing
- **Reset values:** `pcnt`=0, `dcnt`=0, `spd_q`=0, `POS`=`N_LEDS-1`, `DIR`=0, `LEDS`=only bit `N_LEDS-1` set, `STEP`=0.
- **Step edge:** the step is the edge where the tick and divider-match conditions both hold. On that edge `POS`, `DIR`, `LEDS` and `STEP`=1 all update together. `STEP` returns to 0 on the next edge.
- **First step after reset release:** with `ENABLE`=1 throughout, `STEP` is first high in cycle `PRESCALE*(spd_q+1)`. Cycle 1 is the first edge after `RSTn` rises. `spd_q` is the `SPEED` value sampled at reset release.
- **Step spacing:** consecutive `STEP` pulses are exactly `PRESCALE*(SPEED+1)` enabled cycles apart.
- **PRESCALE=1:** every enabled cycle is a tick. With `SPEED`=0, `STEP` is high on every enabled cycle.
- **Reset mid-operation:** `RSTn` low forces all registers to their reset values immediately, without waiting for a clock edge. There is no partial step.

## Configuration
- **`LED_SCANNER_TRAIL_EN` defined:**
  - Adds register `prev`, which holds the `POS` value before the last step. `prev` resets to `N_LEDS-1`.
  - `LEDS` = one-hot(`POS`) | one-hot(`prev`). Two LEDs are lit after the first move; one LED is lit while `POS`=`prev`, including after reset and in hold mode.
  - In hold mode `prev`←`POS` on each step, so the trail collapses after one step.
- **Not defined:** no `prev` register; `LEDS` is strictly one-hot(`POS`).

## Test plan
- **Reset and first step.** Config: `N_LEDS`=8, `PRESCALE`=2, `SPEED`=0, `MODE`=00.
  - Stimulus: release reset.
  - Required: `LEDS`=8'h80 and `POS`=7 until the first step. `STEP` is high in cycle 2 with `POS`=6 and `LEDS`=8'h40.
- **Bounce sequence.** Same config, 14 steps.
  - Required `POS` sequence: 6,5,4,3,2,1,0,1,2,3,4,5,6,7, then 6. `DIR` flips on the steps that land on 1 and on 6.
- **Wrap and hold.**
  - Stimulus: `MODE`=01 starting from `POS`=7.
  - Required: the next step gives `POS`=0, `DIR`=1.
  - Stimulus: `MODE`=11.
  - Required: `STEP` keeps pulsing every 2 cycles while `POS` stays constant.
- **Speed and enable.**
  - Stimulus: `SPEED`=3 with `PRESCALE`=2.
  - Required: `STEP` pulses are 8 cycles apart.
  - Stimulus: `ENABLE`=0 for 5 cycles mid-period.
  - Required: that gap stretches to 13 cycles, and all outputs stay frozen during the low period.
- **Asynchronous reset.**
  - Stimulus: assert `RSTn` low between clock edges mid-run.
  - Required: `LEDS`=8'h80, `POS`=7, `DIR`=0 and `STEP`=0 immediately, without waiting for an edge.
- **Trail build.** Build with `LED_SCANNER_TRAIL_EN`, bounce mode.
  - Required: after step 1, `LEDS`=8'hC0; after step 7 (`POS`=0), `LEDS`=8'h03; after step 8, `LEDS`=8'h03 (`POS`=1, `prev`=0).

Source files
------------

// File: rtl/led_scanner_if.sv
// ----------------------------------------------------------------------------
// led_scanner_if
// Bundles the control inputs and display outputs of the LED scanner.
//
// Signals:
//   enable  : run when high, freeze all scanner state when low
//   mode    : 00 bounce, 01 wrap up, 10 wrap down, 11 hold
//   speed   : step period is PRESCALE*(speed+1) clock cycles
//   leds    : registered LED drive, bit N_LEDS-1 is the leftmost LED
//   pos     : registered index of the lit LED
//   dir     : registered direction, 1 = increasing index
//   step    : one-cycle pulse marking a position update
//
// Modports:
//   master : drives the controls, observes the outputs (controller / bench)
//   slave  : the scanner itself
// ----------------------------------------------------------------------------
interface led_scanner_if #(
    parameter int N_LEDS = 8,
    parameter int PW     = $clog2(N_LEDS)
);
    logic              enable;
    logic [1:0]        mode;
    logic [3:0]        speed;
    logic [N_LEDS-1:0] leds;
    logic [PW-1:0]     pos;
    logic              dir;
    logic              step;

    modport master (
        output enable, mode, speed,
        input  leds, pos, dir, step
    );

    modport slave (
        input  enable, mode, speed,
        output leds, pos, dir, step
    );
endinterface

// File: rtl/led_scanner.sv
// ----------------------------------------------------------------------------
// led_scanner
// Walks a single lit LED across an N_LEDS-wide bar. A prescaler produces a
// base tick every PRESCALE cycles, a speed divider turns every (speed+1)
// ticks into a step, and each step moves the position according to the
// selected pattern (bounce, wrap up, wrap down, hold).
//
// Ports:
//   i_clk   : single clock, all state on its rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : led_scanner_if.slave (enable/mode/speed in, leds/pos/dir/step out)
//
// Optional feature:
//   LED_SCANNER_TRAIL_EN : when defined, the LED of the previous position is
//                          also lit, giving a two-LED trail.
// ----------------------------------------------------------------------------
module led_scanner #(
    parameter int N_LEDS   = 8,
    parameter int PRESCALE = 1250000,
    parameter int PW       = $clog2(N_LEDS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    led_scanner_if.slave  bus
);

    // PRESCALE=1 would give a zero-width counter; keep one bit that stays 0.
    localparam int              PCW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0]  PCNT_MAX   = PCW'(PRESCALE - 1);
    localparam logic [PW-1:0]   POS_MAX    = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]   POS_MAX_M1 = PW'(N_LEDS - 2);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [PCW-1:0]    r_pcnt;
    logic [3:0]        r_dcnt;
    logic [3:0]        r_spd_q;
    logic              r_loaded;
    logic [PW-1:0]     r_pos;
    logic              r_dir;
    logic [N_LEDS-1:0] r_leds;
    logic              r_step;
`ifdef LED_SCANNER_TRAIL_EN
    logic [PW-1:0]     r_prev;
    logic [PW-1:0]     w_prev_nxt;
`endif

    logic [3:0]        w_spd_eff;
    logic              w_tick;
    logic              w_step;
    logic [PCW-1:0]    w_pcnt_nxt;
    logic [3:0]        w_dcnt_nxt;
    logic [3:0]        w_spd_nxt;
    logic [PW-1:0]     w_pos_nxt;
    logic              w_dir_nxt;
    logic [N_LEDS-1:0] w_leds_nxt;
    mode_e             w_mode;

    function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
        onehot = {{(N_LEDS-1){1'b0}}, 1'b1} << p;
    endfunction

    // On the first edge after reset release spd_q has not yet captured SPEED,
    // so the divider compares against the live input for that one edge.
    assign w_spd_eff = r_loaded ? r_spd_q : bus.speed;
    assign w_tick    = bus.enable && (r_pcnt == PCNT_MAX);
    assign w_step    = w_tick && (r_dcnt == w_spd_eff);
    assign w_mode    = mode_e'(bus.mode);

    always_comb begin
        w_pcnt_nxt = r_pcnt;
        w_dcnt_nxt = r_dcnt;
        w_spd_nxt  = r_spd_q;
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir;
`ifdef LED_SCANNER_TRAIL_EN
        w_prev_nxt = r_prev;
`endif

        if (bus.enable) begin
            w_pcnt_nxt = w_tick ? '0 : r_pcnt + 1'b1;
        end

        if (w_tick) begin
            w_dcnt_nxt = w_step ? 4'd0 : r_dcnt + 4'd1;
        end

        // A new SPEED only takes effect for the period that starts here.
        if (!r_loaded || w_step) begin
            w_spd_nxt = bus.speed;
        end

        if (w_step) begin
`ifdef LED_SCANNER_TRAIL_EN
            w_prev_nxt = r_pos;
`endif
            unique case (w_mode)
                MODE_BOUNCE: begin
                    // Turn around at each end so both ends are visited once.
                    if (!r_dir && (r_pos == '0)) begin
                        w_dir_nxt = 1'b1;
                        w_pos_nxt = PW'(1);
                    end else if (r_dir && (r_pos >= POS_MAX)) begin
                        w_dir_nxt = 1'b0;
                        w_pos_nxt = POS_MAX_M1;
                    end else if (r_dir) begin
                        w_pos_nxt = r_pos + PW'(1);
                    end else begin
                        w_pos_nxt = r_pos - PW'(1);
                    end
                end
                MODE_UP: begin
                    w_dir_nxt = 1'b1;
                    w_pos_nxt = (r_pos >= POS_MAX) ? '0 : r_pos + PW'(1);
                end
                MODE_DOWN: begin
                    w_dir_nxt = 1'b0;
                    w_pos_nxt = (r_pos == '0) ? POS_MAX : r_pos - PW'(1);
                end
                MODE_HOLD: begin
                    w_pos_nxt = r_pos;
                    w_dir_nxt = r_dir;
                end
                default: begin
                    w_pos_nxt = r_pos;
                    w_dir_nxt = r_dir;
                end
            endcase
        end

`ifdef LED_SCANNER_TRAIL_EN
        w_leds_nxt = onehot(w_pos_nxt) | onehot(w_prev_nxt);
`else
        w_leds_nxt = onehot(w_pos_nxt);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt   <= '0;
            r_dcnt   <= 4'd0;
            r_spd_q  <= 4'd0;
            r_loaded <= 1'b0;
            r_pos    <= POS_MAX;
            r_dir    <= 1'b0;
            r_leds   <= onehot(POS_MAX);
            r_step   <= 1'b0;
`ifdef LED_SCANNER_TRAIL_EN
            r_prev   <= POS_MAX;
`endif
        end else begin
            r_pcnt   <= w_pcnt_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_spd_q  <= w_spd_nxt;
            r_loaded <= 1'b1;
            r_pos    <= w_pos_nxt;
            r_dir    <= w_dir_nxt;
            r_leds   <= w_leds_nxt;
            r_step   <= w_step;
`ifdef LED_SCANNER_TRAIL_EN
            r_prev   <= w_prev_nxt;
`endif
        end
    end

    assign bus.leds = r_leds;
    assign bus.pos  = r_pos;
    assign bus.dir  = r_dir;
    assign bus.step = r_step;

endmodule

// File: tb/tb_led_scanner.sv
// ----------------------------------------------------------------------------
// tb_led_scanner
// Bench for led_scanner: an 8-LED instance with PRESCALE=2 covers reset,
// bounce, wrap, hold, speed, enable and asynchronous reset; a 5-LED instance
// with PRESCALE=1 covers the every-cycle step and non-power-of-two wrap.
// Honours LED_SCANNER_TRAIL_EN for the expected LED patterns.
// ----------------------------------------------------------------------------
module tb_led_scanner;

    localparam int N   = 8;
    localparam int PRE = 2;
    localparam int N2  = 5;
`ifdef LED_SCANNER_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_scanner_if #(.N_LEDS(N),  .PW(3)) bus  ();
    led_scanner_if #(.N_LEDS(N2), .PW(3)) bus2 ();

    led_scanner #(.N_LEDS(N), .PRESCALE(PRE)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    led_scanner #(.N_LEDS(N2), .PRESCALE(1)) dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus2)
    );

    typedef struct {
        logic [2:0] pos;
        logic       dir;
        logic [7:0] leds;
        logic [7:0] leds_tr;
    } vec_t;

    vec_t tbl [15];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sel(input logic [7:0] plain, input logic [7:0] trail);
        return TRAIL ? trail : plain;
    endfunction

    // Advance edge by edge until STEP is seen (bounded), sampling 1 after the edge.
    task automatic next_step(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.step && cycles < 100);
        check("step_seen", 64'(bus.step), 64'(1));
    endtask

    task automatic check_out(input string tag, input logic [2:0] p, input logic d,
                             input logic [7:0] l);
        check({tag, "_pos"},  64'(bus.pos),  64'(p));
        check({tag, "_dir"},  64'(bus.dir),  64'(d));
        check({tag, "_leds"}, 64'(bus.leds), 64'(l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int g;
        int pos2;
        int prev2;
        logic [4:0] exp2;

        tbl[0]  = '{3'd6, 1'b0, 8'h40, 8'hC0};
        tbl[1]  = '{3'd5, 1'b0, 8'h20, 8'h60};
        tbl[2]  = '{3'd4, 1'b0, 8'h10, 8'h30};
        tbl[3]  = '{3'd3, 1'b0, 8'h08, 8'h18};
        tbl[4]  = '{3'd2, 1'b0, 8'h04, 8'h0C};
        tbl[5]  = '{3'd1, 1'b0, 8'h02, 8'h06};
        tbl[6]  = '{3'd0, 1'b0, 8'h01, 8'h03};
        tbl[7]  = '{3'd1, 1'b1, 8'h02, 8'h03};
        tbl[8]  = '{3'd2, 1'b1, 8'h04, 8'h06};
        tbl[9]  = '{3'd3, 1'b1, 8'h08, 8'h0C};
        tbl[10] = '{3'd4, 1'b1, 8'h10, 8'h18};
        tbl[11] = '{3'd5, 1'b1, 8'h20, 8'h30};
        tbl[12] = '{3'd6, 1'b1, 8'h40, 8'h60};
        tbl[13] = '{3'd7, 1'b1, 8'h80, 8'hC0};
        tbl[14] = '{3'd6, 1'b0, 8'h40, 8'hC0};

        rst_n       = 1'b0;
        bus.enable  = 1'b1;
        bus.mode    = 2'b00;
        bus.speed   = 4'd0;
        bus2.enable = 1'b0;
        bus2.mode   = 2'b01;
        bus2.speed  = 4'd0;

        // Reset state
        #12;
        check_out("rst", 3'd7, 1'b0, 8'h80);
        check("rst_step", 64'(bus.step), 64'(0));
        #5;
        rst_n = 1'b1;

        // Cycle 1: still the reset picture
        @(posedge clk);
        #1;
        check("c1_step", 64'(bus.step), 64'(0));
        check_out("c1", 3'd7, 1'b0, 8'h80);

        // Bounce sequence, first step in cycle 2
        for (int i = 0; i < 15; i++) begin
            next_step(g);
            check("bounce_gap", 64'(g), 64'((i == 0) ? 1 : 2));
            check_out("bounce", tbl[i].pos, tbl[i].dir, sel(tbl[i].leds, tbl[i].leds_tr));
        end
        @(posedge clk);
        #1;
        check("step_low", 64'(bus.step), 64'(0));

        // Wrap up: 6 -> 7 -> 0
        bus.mode = 2'b01;
        next_step(g);
        check("up_gap", 64'(g), 64'(1));
        check_out("up1", 3'd7, 1'b1, sel(8'h80, 8'hC0));
        next_step(g);
        check_out("up2", 3'd0, 1'b1, sel(8'h01, 8'h81));

        // Wrap down: 0 -> 7
        bus.mode = 2'b10;
        next_step(g);
        check_out("down", 3'd7, 1'b0, sel(8'h80, 8'h81));

        // Hold: STEP keeps pulsing every 2 cycles, position constant
        bus.mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            next_step(g);
            check("hold_gap", 64'(g), 64'(2));
            check_out("hold", 3'd7, 1'b0, 8'h80);
        end

        // Speed change affects the following period only
        bus.mode  = 2'b00;
        bus.speed = 4'd3;
        next_step(g);
        check("spd_gap_old", 64'(g), 64'(2));
        check_out("spd1", 3'd6, 1'b0, sel(8'h40, 8'hC0));
        next_step(g);
        check("spd_gap_new", 64'(g), 64'(8));
        check_out("spd2", 3'd5, 1'b0, sel(8'h20, 8'h60));

        // ENABLE low for 5 cycles mid-period stretches the gap to 13
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.enable = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("frz_step", 64'(bus.step), 64'(0));
            check_out("frz", 3'd5, 1'b0, sel(8'h20, 8'h60));
        end
        bus.enable = 1'b1;
        next_step(g);
        check("en_gap", 64'(8 + g), 64'(13));
        check_out("en", 3'd4, 1'b0, sel(8'h10, 8'h30));

        // Asynchronous reset right after a step edge, between clock edges
        next_step(g);
        check_out("pre_rst", 3'd3, 1'b0, sel(8'h08, 8'h18));
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst", 3'd7, 1'b0, 8'h80);
        check("arst_step", 64'(bus.step), 64'(0));
        bus.speed = 4'd1;
        @(negedge clk);
        rst_n = 1'b1;
        next_step(g);
        check("rel_gap", 64'(g), 64'(4));
        check_out("rel", 3'd6, 1'b0, sel(8'h40, 8'hC0));

        // PRESCALE=1, SPEED=0, 5 LEDs wrapping up: a step on every cycle
        bus2.enable = 1'b1;
        pos2  = 4;
        prev2 = 4;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            prev2 = pos2;
            pos2  = (pos2 == 4) ? 0 : pos2 + 1;
            exp2  = 5'(1 << pos2);
            if (TRAIL) exp2 = exp2 | 5'(1 << prev2);
            check("p1_step", 64'(bus2.step), 64'(1));
            check("p1_pos",  64'(bus2.pos),  64'(pos2));
            check("p1_leds", 64'(bus2.leds), 64'(exp2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
